// File: rtl/mem_slv_pipe.sv
// mem_slv_pipe: memory-side slave stage behind the mem_req/mem_res channels.
// Each accepted request reads or writes one 512-bit line of an internal store.
// Responses come back in order after at least LAT cycles, held in a small queue.
// Optional feature macro: MEM_SLV_ERR_INJ_EN adds err_inj_i. When err_inj_i is
// high at accept, the entry is flagged err=1, returns zero data, and never
// touches the store.
module mem_slv_pipe #(
  parameter int IDX_W    = 4,
  parameter int PCN_W    = 28,
  parameter int DEPTH_LG = 10,
  parameter int LAT      = 4,
  parameter int QDEPTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MEM_SLV_ERR_INJ_EN
  input  logic             err_inj_i,
`endif
  input  logic             mem_req_i_valid,
  output logic             mem_req_i_ready,
  input  logic [IDX_W-1:0] mem_req_i_bits_idx,
  input  logic             mem_req_i_bits_wnr,
  input  logic [2:0]       mem_req_i_bits_siz,
  input  logic [PCN_W-1:0] mem_req_i_bits_pcn,
  input  logic [511:0]     mem_req_i_bits_data,
  output logic             mem_res_o_valid,
  input  logic             mem_res_o_ready,
  output logic [IDX_W-1:0] mem_res_o_bits_idx,
  output logic             mem_res_o_bits_err,
  output logic             mem_res_o_bits_wnr,
  output logic [2:0]       mem_res_o_bits_siz,
  output logic [511:0]     mem_res_o_bits_data
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  // The counter only ever holds values 0..LAT-1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  // Backing store: deliberately not reset so contents survive a reset pulse.
  logic [511:0]          store_q [2**DEPTH_LG];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]      q_idx_q  [QDEPTH];
  logic [IDX_W-1:0]      q_idx_d  [QDEPTH];
  logic                  q_wnr_q  [QDEPTH];
  logic                  q_wnr_d  [QDEPTH];
  logic [2:0]            q_siz_q  [QDEPTH];
  logic [2:0]            q_siz_d  [QDEPTH];
  logic                  q_err_q  [QDEPTH];
  logic                  q_err_d  [QDEPTH];
  logic [CW-1:0]         q_cnt_q  [QDEPTH];
  logic [CW-1:0]         q_cnt_d  [QDEPTH];
  logic [511:0]          q_data_q [QDEPTH];
  logic [511:0]          q_data_d [QDEPTH];

  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  pop;
  logic                  inj_err;
  logic                  req_err;
  logic                  entry_err;
  logic [DEPTH_LG-1:0]   store_addr;
  logic                  store_we;
  logic [511:0]          entry_data;
  logic [AW-1:0]         wr_slot;
  logic [AW-1:0]         rd_slot;

`ifdef MEM_SLV_ERR_INJ_EN
  assign inj_err = err_inj_i;
`else
  assign inj_err = 1'b0;
`endif

  assign wr_slot = wr_ptr_q[AW-1:0];
  assign rd_slot = rd_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Ready ignores a same-cycle pop: no bypass when full. Forced low in reset.
  assign mem_req_i_ready = !reset && !full;
  assign accept          = mem_req_i_valid && mem_req_i_ready;

  // Pointers clear asynchronously, so valid drops with reset without a clock.
  assign mem_res_o_valid = !empty && (q_cnt_q[rd_slot] == '0);
  assign pop             = mem_res_o_valid && mem_res_o_ready;

  assign req_err    = (mem_req_i_bits_siz != 3'd6) ||
                      ((mem_req_i_bits_pcn >> DEPTH_LG) != '0);
  assign entry_err  = req_err || inj_err;
  assign store_addr = mem_req_i_bits_pcn[DEPTH_LG-1:0];
  assign store_we   = accept && mem_req_i_bits_wnr && !entry_err;
  // Reads sample the store at the accept edge; writes and errors carry zero.
  assign entry_data = (!mem_req_i_bits_wnr && !entry_err) ? store_q[store_addr] : '0;

  assign mem_res_o_bits_idx  = reset ? '0   : q_idx_q[rd_slot];
  assign mem_res_o_bits_err  = reset ? 1'b0 : q_err_q[rd_slot];
  assign mem_res_o_bits_wnr  = reset ? 1'b0 : q_wnr_q[rd_slot];
  assign mem_res_o_bits_siz  = reset ? '0   : q_siz_q[rd_slot];
  assign mem_res_o_bits_data = reset ? '0   : q_data_q[rd_slot];

  // Next-state for pointers, per-entry latency counters and entry fields.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(accept);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    q_idx_d  = q_idx_q;
    q_wnr_d  = q_wnr_q;
    q_siz_d  = q_siz_q;
    q_err_d  = q_err_q;
    q_data_d = q_data_q;
    for (int i = 0; i < QDEPTH; i++) begin
      q_cnt_d[i] = (q_cnt_q[i] != '0) ? q_cnt_q[i] - CW'(1) : '0;
    end
    if (accept) begin
      q_idx_d[wr_slot]  = mem_req_i_bits_idx;
      q_wnr_d[wr_slot]  = mem_req_i_bits_wnr;
      q_siz_d[wr_slot]  = mem_req_i_bits_siz;
      q_err_d[wr_slot]  = entry_err;
      q_data_d[wr_slot] = entry_data;
      q_cnt_d[wr_slot]  = CNT_INIT;
    end
  end

  // Control state and entry metadata, cleared asynchronously on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_idx_q[i] <= '0;
        q_wnr_q[i] <= 1'b0;
        q_siz_q[i] <= '0;
        q_err_q[i] <= 1'b0;
        q_cnt_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_idx_q  <= q_idx_d;
      q_wnr_q  <= q_wnr_d;
      q_siz_q  <= q_siz_d;
      q_err_q  <= q_err_d;
      q_cnt_q  <= q_cnt_d;
    end
  end

  // Entry payload is only observable once its slot is valid, so it needs no reset.
  always_ff @(posedge clock) begin
    q_data_q <= q_data_d;
  end

  // Store write port; the store is the single point of request ordering.
  always_ff @(posedge clock) begin
    if (store_we) begin
      store_q[store_addr] <= mem_req_i_bits_data;
    end
  end

endmodule

// File: tb/tb_mem_slv_pipe.sv
// Directed self-checking bench for mem_slv_pipe (default parameters, LAT=4, QDEPTH=8).
module tb_mem_slv_pipe;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
`ifdef MEM_SLV_ERR_INJ_EN
  logic          err_inj_i = 1'b0;
`endif
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_idx = '0;
  logic          req_wnr = 1'b0;
  logic [2:0]    req_siz = 3'd6;
  logic [27:0]   req_pcn = '0;
  logic [511:0]  req_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [3:0]    res_idx;
  logic          res_err;
  logic          res_wnr;
  logic [2:0]    res_siz;
  logic [511:0]  res_data;

  int tests = 0;
  int fails = 0;

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};
  localparam logic [511:0] PAT_3C = {64{8'h3C}};
  localparam logic [511:0] PAT_FF = {64{8'hFF}};
  localparam logic [511:0] PAT_22 = {64{8'h22}};
  localparam logic [511:0] PAT_11 = {64{8'h11}};

  mem_slv_pipe dut (
    .clock               (clock),
    .reset               (reset),
`ifdef MEM_SLV_ERR_INJ_EN
    .err_inj_i           (err_inj_i),
`endif
    .mem_req_i_valid     (req_valid),
    .mem_req_i_ready     (req_ready),
    .mem_req_i_bits_idx  (req_idx),
    .mem_req_i_bits_wnr  (req_wnr),
    .mem_req_i_bits_siz  (req_siz),
    .mem_req_i_bits_pcn  (req_pcn),
    .mem_req_i_bits_data (req_data),
    .mem_res_o_valid     (res_valid),
    .mem_res_o_ready     (res_ready),
    .mem_res_o_bits_idx  (res_idx),
    .mem_res_o_bits_err  (res_err),
    .mem_res_o_bits_wnr  (res_wnr),
    .mem_res_o_bits_siz  (res_siz),
    .mem_res_o_bits_data (res_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_req(input logic [3:0] idx, input logic wnr, input logic [2:0] siz,
                         input logic [27:0] pcn, input logic [511:0] data);
    req_valid = 1'b1;
    req_idx   = idx;
    req_wnr   = wnr;
    req_siz   = siz;
    req_pcn   = pcn;
    req_data  = data;
  endtask

  // Present one request for one edge; expects the slave to be ready.
  task automatic send(input logic [3:0] idx, input logic wnr, input logic [2:0] siz,
                      input logic [27:0] pcn, input logic [511:0] data);
    set_req(idx, wnr, siz, pcn, data);
    chk("send_ready", 512'(req_ready), 512'(1));
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 30 && !res_valid; c++) step();
    chk("wait_valid", 512'(res_valid), 512'(1));
  endtask

  int nxt;
  int got;
  int hs;
  int stale;
  logic [3:0] exp_idx;

  initial begin
    // Reset state
    step();
    chk("rst_valid", 512'(res_valid), 512'(0));
    chk("rst_ready", 512'(req_ready), 512'(0));
    chk("rst_idx",   512'(res_idx),   512'(0));
    chk("rst_data",  res_data,        '0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 512'(req_ready), 512'(1));

    // Write then read, exact latency of 4 cycles
    send(4'd1, 1'b1, 3'd6, 28'h5, PAT_A5);
    send(4'd2, 1'b0, 3'd6, 28'h5, '0);
    chk("lat_early2", 512'(res_valid), 512'(0));
    step();
    chk("lat_early3", 512'(res_valid), 512'(0));
    step();
    chk("wr_valid", 512'(res_valid), 512'(1));
    chk("wr_idx",   512'(res_idx),   512'(1));
    chk("wr_wnr",   512'(res_wnr),   512'(1));
    chk("wr_err",   512'(res_err),   512'(0));
    chk("wr_siz",   512'(res_siz),   512'(6));
    chk("wr_data",  res_data,        '0);
    step();
    chk("rd_valid", 512'(res_valid), 512'(1));
    chk("rd_idx",   512'(res_idx),   512'(2));
    chk("rd_wnr",   512'(res_wnr),   512'(0));
    chk("rd_err",   512'(res_err),   512'(0));
    chk("rd_data",  res_data,        PAT_A5);
    step();
    chk("rd_drained", 512'(res_valid), 512'(0));

    // Illegal requests
    send(4'd3, 1'b0, 3'd3, 28'h5, '0);
    wait_valid();
    chk("siz_err",  512'(res_err),  512'(1));
    chk("siz_echo", 512'(res_siz),  512'(3));
    chk("siz_idx",  512'(res_idx),  512'(3));
    chk("siz_data", res_data,       '0);
    step();
    send(4'd4, 1'b0, 3'd6, 28'h400, '0);
    wait_valid();
    chk("pcn_err",  512'(res_err),  512'(1));
    chk("pcn_idx",  512'(res_idx),  512'(4));
    chk("pcn_data", res_data,       '0);
    step();
    send(4'd5, 1'b1, 3'd3, 28'h5, PAT_FF);
    wait_valid();
    chk("badwr_err",  512'(res_err), 512'(1));
    chk("badwr_wnr",  512'(res_wnr), 512'(1));
    chk("badwr_data", res_data,      '0);
    step();
    step();
    chk("ill_drained", 512'(res_valid), 512'(0));

    // Queue fill under backpressure: 10 offered, 8 accepted
    res_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 12; c++) begin
      if (nxt < 10) set_req(4'(nxt), 1'b0, 3'd6, 28'h5, '0);
      else req_valid = 1'b0;
      if (req_valid && req_ready) nxt++;
      step();
    end
    chk("fill_accepted", 512'(nxt), 512'(8));
    chk("fill_ready0",   512'(req_ready), 512'(0));
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      if (nxt < 10) set_req(4'(nxt), 1'b0, 3'd6, 28'h5, '0);
      else req_valid = 1'b0;
      if (req_valid && req_ready) nxt++;
      if (res_valid) begin
        chk("fill_order", 512'(res_idx), 512'(got));
        chk("fill_data",  res_data,      PAT_A5);
        got++;
      end
      step();
    end
    req_valid = 1'b0;
    chk("fill_total_acc", 512'(nxt), 512'(10));
    chk("fill_total_res", 512'(got), 512'(10));

    // Backpressure stability
    res_ready = 1'b0;
    send(4'd5, 1'b1, 3'd6, 28'h6, PAT_3C);
    send(4'd6, 1'b0, 3'd6, 28'h6, '0);
    wait_valid();
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 512'(res_valid), 512'(1));
      chk("stall_idx",   512'(res_idx),   512'(5));
      chk("stall_data",  res_data,        '0);
      step();
    end
    res_ready = 1'b1;
    hs = 0;
    exp_idx = 4'd5;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) begin
        chk("bp_idx", 512'(res_idx), 512'(exp_idx));
        if (exp_idx == 4'd6) chk("bp_rd_data", res_data, PAT_3C);
        exp_idx = exp_idx + 4'd1;
        hs++;
      end
      step();
    end
    chk("bp_handshakes", 512'(hs), 512'(2));

    // Asynchronous reset with 5 entries queued
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i), 1'b0, 3'd6, 28'h6, '0);
    step();
    step();
    step();
    chk("pre_rst_valid", 512'(res_valid), 512'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 512'(res_valid), 512'(0));
    chk("async_ready", 512'(req_ready), 512'(0));
    step();
    reset = 1'b0;
    res_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      if (res_valid) stale++;
      step();
    end
    chk("no_stale", 512'(stale), 512'(0));
    send(4'd7, 1'b0, 3'd6, 28'h6, '0);
    wait_valid();
    chk("persist_idx",  512'(res_idx), 512'(7));
    chk("persist_data", res_data,      PAT_3C);
    step();

`ifdef MEM_SLV_ERR_INJ_EN
    // Error injection: injected write must not reach the store
    send(4'd8, 1'b1, 3'd6, 28'h7, PAT_22);
    wait_valid();
    step();
    err_inj_i = 1'b1;
    send(4'd9, 1'b1, 3'd6, 28'h7, PAT_11);
    err_inj_i = 1'b0;
    wait_valid();
    chk("inj_err",  512'(res_err), 512'(1));
    chk("inj_data", res_data,      '0);
    step();
    send(4'd10, 1'b0, 3'd6, 28'h7, '0);
    wait_valid();
    chk("inj_rd_err",  512'(res_err), 512'(0));
    chk("inj_rd_data", res_data,      PAT_22);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
